// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencer.
package mac_seq_ctrl_pkg;

   localparam int LANES_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_A,
      FILL,
      SETTLE,
      OUT
   } state_t;

   localparam logic [1:0] OP_WR_W = 2'b00;
   localparam logic [1:0] OP_WR_A = 2'b01;
   localparam logic [1:0] OP_NOP  = 2'b11;

endpackage

// File: rtl/mac_result_ser.sv
// Captures an adder-tree sum and streams it out as three little-endian bytes.
module mac_result_ser #(
   parameter int SUM_W = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SUM_W-1:0] sum,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             last_hs
);

   logic [SUM_W-1:0] sum_q;
   logic [1:0]       idx;
   logic [23:0]      ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= '0;
         idx       <= 2'd0;
         out_valid <= 1'b0;
      end else if (load) begin
         sum_q     <= sum;
         idx       <= 2'd0;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         if (idx == 2'd2) begin
            idx       <= 2'd0;
            out_valid <= 1'b0;
         end else begin
            idx <= idx + 2'd1;
         end
      end
   end

   // Zero-extend so the top byte carries only the sum's upper bits.
   always_comb begin
      ext              = '0;
      ext[SUM_W-1:0]   = sum_q;
   end

   always_comb begin
      case (idx)
         2'd0:    out_data = ext[7:0];
         2'd1:    out_data = ext[15:8];
         default: out_data = ext[23:16];
      endcase
   end

   assign last_hs = out_valid && out_ready && (idx == 2'd2);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Byte-stream sequencer: loads weights/activations into a MAC array, pads
// unused lanes with zero activations, then returns the adder-tree sum.
module mac_seq_ctrl
   import mac_seq_ctrl_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int DW    = 8,
   parameter int SUM_W = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       mac_op,
   output logic [5:0]       mac_addr,
   output logic [DW-1:0]    mac_data,
   input  logic [SUM_W-1:0] sum_in,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

   localparam logic [5:0] LANES6 = 6'(LANES);

   state_t     state;
   logic [5:0] cnt;
   logic [3:0] n_q;
   logic       hdr_bad;
   logic       last_byte;
   logic       ser_last;

   assign hdr_bad   = (in_data[3:0] == 4'd0) || ({2'b00, in_data[3:0]} > LANES6);
   assign last_byte = (cnt == ({2'b00, n_q} - 6'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         n_q   <= '0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               if (hdr_bad) begin
                  err <= 1'b1;
               end else begin
                  n_q   <= in_data[3:0];
                  cnt   <= '0;
                  state <= in_data[7] ? LOAD_A : LOAD_W;
               end
            end
            LOAD_W: if (in_valid) begin
               if (last_byte) begin
                  cnt   <= '0;
                  state <= LOAD_A;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            LOAD_A: if (in_valid) begin
               if (last_byte) begin
                  // Counter continues from N so FILL walks the unused lanes.
                  cnt   <= {2'b00, n_q};
                  state <= ({2'b00, n_q} < LANES6) ? FILL : SETTLE;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            FILL: begin
               if (cnt == LANES6 - 6'd1) begin
                  cnt   <= '0;
                  state <= SETTLE;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            SETTLE: begin
               cnt   <= '0;
               state <= OUT;
            end
            OUT: if (ser_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE) || (state == LOAD_W) || (state == LOAD_A);
   assign busy     = (state != IDLE);

   // Array writes follow the accepted byte within the same cycle.
   always_comb begin
      mac_op   = OP_NOP;
      mac_addr = '0;
      mac_data = '0;
      case (state)
         LOAD_W: if (in_valid) begin
            mac_op   = OP_WR_W;
            mac_addr = cnt;
            mac_data = in_data;
         end
         LOAD_A: if (in_valid) begin
            mac_op   = OP_WR_A;
            mac_addr = cnt;
            mac_data = in_data;
         end
         FILL: begin
            mac_op   = OP_WR_A;
            mac_addr = cnt;
         end
         default: ;
      endcase
   end

   mac_result_ser #(.SUM_W(SUM_W)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state == SETTLE),
      .sum       (sum_in),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .last_hs   (ser_last)
   );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl with a behavioural MAC array and result model.
module tb_mac_seq_ctrl;

   localparam int LANES = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  mac_op;
   logic [5:0]  mac_addr;
   logic [7:0]  mac_data;
   logic [18:0] sum_in;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   // Physical array contents (what the DUT wrote) and the reference contents.
   logic [7:0] arr_w [LANES];
   logic [7:0] arr_a [LANES];
   int         ref_w [LANES];
   int         ref_a [LANES];
   logic [7:0] txw   [LANES];
   logic [7:0] txa   [LANES];

   mac_seq_ctrl #(.LANES(LANES), .DW(8), .SUM_W(19)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mac_op(mac_op), .mac_addr(mac_addr), .mac_data(mac_data),
      .sum_in(sum_in), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < LANES; i++) begin
         arr_w[i] = '0; arr_a[i] = '0; ref_w[i] = 0; ref_a[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (mac_op == 2'b00) arr_w[mac_addr[2:0]] <= mac_data;
      else if (mac_op == 2'b01) arr_a[mac_addr[2:0]] <= mac_data;
   end

   always_comb begin
      sum_in = '0;
      for (int i = 0; i < LANES; i++) sum_in = sum_in + 19'(arr_w[i]) * 19'(arr_a[i]);
   end

   task automatic send_byte(input logic [7:0] b, input logic [1:0] eop,
                            input int eaddr, input logic [7:0] edata);
      bit ok = 0;
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         else begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL send_timeout byte=%02h in_ready=%b expected 1", b, in_ready);
      end else if (mac_op !== eop || mac_addr !== 6'(eaddr) || mac_data !== edata) begin
         n_bad++;
         $display("FAIL mac_write op=%b addr=%0d data=%02h expected op=%b addr=%0d data=%02h",
                  mac_op, mac_addr, mac_data, eop, eaddr, edata);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_txn(input int n, input bit keep, input bit rnd_ready, input int stall);
      int          exp_sum = 0;
      logic [23:0] exp_v;
      logic [7:0]  exp_b;
      int          lat = 0;
      bit          hs;
      send_byte({keep, 3'b000, 4'(n)}, 2'b11, 0, 8'h00);
      if (!keep) begin
         for (int i = 0; i < n; i++) begin
            send_byte(txw[i], 2'b00, i, txw[i]);
            ref_w[i] = int'(txw[i]);
         end
      end
      for (int i = 0; i < n; i++) begin
         send_byte(txa[i], 2'b01, i, txa[i]);
         ref_a[i] = int'(txa[i]);
      end
      for (int i = n; i < LANES; i++) ref_a[i] = 0;
      for (int i = 0; i < LANES; i++) exp_sum += ref_w[i] * ref_a[i];
      exp_v = 24'(exp_sum);

      // Zero fill for the unused lanes, then one settle cycle, then output.
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (out_valid) break;
         n_cmp++;
         if (lat < LANES - n) begin
            if (mac_op !== 2'b01 || mac_addr !== 6'(n + lat) || mac_data !== 8'h00 || in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL fill op=%b addr=%0d data=%02h rdy=%b expected op=01 addr=%0d data=00 rdy=0",
                        mac_op, mac_addr, mac_data, in_ready, n + lat);
            end
         end else if (mac_op !== 2'b11 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL settle op=%b rdy=%b busy=%b expected op=11 rdy=0 busy=1", mac_op, in_ready, busy);
         end
         lat++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (lat != LANES - n + 1) begin
         n_bad++;
         $display("FAIL latency cycles=%0d expected %0d", lat, LANES - n + 1);
      end

      for (int k = 0; k < 3; k++) begin
         exp_b = exp_v[8*k +: 8];
         hs = 0;
         for (int t = 0; t < 60 && !hs; t++) begin
            if (k == 0 && t < stall) out_ready = 1'b0;
            else if (rnd_ready) out_ready = 1'(($urandom % 3) != 0);
            else out_ready = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_b || in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL out_byte%0d valid=%b data=%02h rdy=%b expected valid=1 data=%02h rdy=0",
                        k, out_valid, out_data, in_ready, exp_b);
            end
            hs = out_ready;
            @(posedge clk); #1;
            @(negedge clk);
         end
         if (!hs) begin
            n_cmp++; n_bad++;
            $display("FAIL out_timeout byte%0d", k);
         end
      end
      out_ready = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL post_out valid=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (mac_op !== 2'b11 || mac_addr !== 6'd0 || mac_data !== 8'd0 || out_valid !== 1'b0 ||
          out_data !== 8'd0 || err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state op=%b addr=%0d data=%02h ov=%b od=%02h err=%b busy=%b",
                  mac_op, mac_addr, mac_data, out_valid, out_data, err, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready got=%b expected 1", in_ready);
      end
   endtask

   task automatic test_known();
      for (int i = 0; i < LANES; i++) begin txw[i] = 8'(i + 1); txa[i] = 8'(i + 1); end
      run_txn(8, 0, 0, 0);
   endtask

   task automatic test_keep();
      txa[0] = 8'd2; txa[1] = 8'd3;
      run_txn(2, 1, 0, 0);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 3; i++) begin txw[i] = 8'hFF; txa[i] = 8'hFF; end
      run_txn(3, 0, 0, 0);
   endtask

   task automatic test_err();
      logic [7:0] hdrs [2];
      hdrs[0] = 8'h00; hdrs[1] = 8'h09;
      for (int h = 0; h < 2; h++) begin
         send_byte(hdrs[h], 2'b11, 0, 8'h00);
         @(negedge clk);
         n_cmp++;
         if (err !== 1'b1 || busy !== 1'b0 || mac_op !== 2'b11) begin
            n_bad++;
            $display("FAIL err_pulse hdr=%02h err=%b busy=%b op=%b expected 1 0 11", hdrs[h], err, busy, mac_op);
         end
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_clear hdr=%02h err=%b busy=%b rdy=%b expected 0 0 1", hdrs[h], err, busy, in_ready);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < LANES; i++) begin txw[i] = 8'($urandom); txa[i] = 8'($urandom); end
      run_txn(6, 0, 0, 10);
   endtask

   task automatic test_mid_reset();
      send_byte(8'h08, 2'b11, 0, 8'h00);
      for (int i = 0; i < LANES; i++) begin
         send_byte(8'(i + 10), 2'b00, i, 8'(i + 10));
         ref_w[i] = i + 10;
      end
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(i + 20), 2'b01, i, 8'(i + 20));
         ref_a[i] = i + 20;
      end
      in_data = 8'h55; in_valid = 1'b1;
      #1; rst_n = 1'b0; #1;
      n_cmp++;
      if (mac_op !== 2'b11 || mac_addr !== 6'd0 || mac_data !== 8'd0 || out_valid !== 1'b0 ||
          out_data !== 8'd0 || err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_state op=%b addr=%0d data=%02h ov=%b od=%02h err=%b busy=%b",
                  mac_op, mac_addr, mac_data, out_valid, out_data, err, busy);
      end
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_release rdy=%b busy=%b expected 1 0", in_ready, busy);
      end
      for (int i = 0; i < LANES; i++) begin txw[i] = 8'($urandom); txa[i] = 8'($urandom); end
      run_txn(5, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < LANES; i++) begin txw[i] = 8'($urandom); txa[i] = 8'($urandom); end
         run_txn(int'($urandom_range(1, LANES)), 1'($urandom % 2), 1, 0);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < LANES; i++) begin txw[i] = 8'hFF; txa[i] = 8'hFF; end
         run_txn(LANES, 0, 0, 0);
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_keep();
      test_fill();
      test_err();
      test_stall();
      test_mid_reset();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
